// File: rtl/mem_wb_pkg.sv
// Purpose : shared opcode/funct3 constants, FSM state type and instruction classifier for the MEM/WB stage.
// Latency : n/a (package only).
// Backpr. : n/a.
package mem_wb_pkg;

    // Major opcode field ex_ir[6:2]
    localparam logic [4:0] OP_RTYPE  = 5'b01100;
    localparam logic [4:0] OP_ITYPE  = 5'b00100;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;

    // Execute inserts this word when it has nothing valid to hand over
    localparam logic [31:0] BUBBLE_IR = 32'hFFFF_FFFF;

    localparam logic [2:0] F3_LB = 3'b000;
    localparam logic [2:0] F3_LW = 3'b010;
    localparam logic [2:0] F3_SW = 3'b010;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } mwb_state_e;

    // What this stage has to do with an instruction
    typedef enum logic [1:0] {
        K_NOP   = 2'd0,
        K_ALU   = 2'd1,
        K_LOAD  = 2'd2,
        K_STORE = 2'd3
    } ir_kind_e;

    // Branches, bubbles and unknown opcodes all fall through to K_NOP.
    function automatic ir_kind_e classify_ir(input logic [31:0] ir);
        ir_kind_e k;
        k = K_NOP;
        if (ir != BUBBLE_IR) begin
            case (ir[6:2])
                OP_RTYPE, OP_ITYPE: k = K_ALU;
                OP_LOAD:            k = K_LOAD;
                OP_STORE:           k = K_STORE;
                OP_BRANCH:          k = K_NOP;
                default:            k = K_NOP;
            endcase
        end
        return k;
    endfunction

endpackage

// File: rtl/mem_wb_load_align.sv
// Purpose : select and extend load data from the raw memory word (LW whole word, LB sign-extended byte, else 0).
// Latency : combinational.
// Backpr. : none.
// Ports   : rdata_i raw read word, addr_lo_i byte offset, funct3_i load width, data_o write-back value.
module mem_wb_load_align
    import mem_wb_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0] byte_sel;

    always_comb begin
        byte_sel = 8'h00;
        case (addr_lo_i)
            2'd0: byte_sel = rdata_i[7:0];
            2'd1: byte_sel = rdata_i[15:8];
            2'd2: byte_sel = rdata_i[23:16];
            2'd3: byte_sel = rdata_i[31:24];
            default: byte_sel = 8'h00;
        endcase
    end

    always_comb begin
        data_o = 32'h0;
        case (funct3_i)
            F3_LW:   data_o = rdata_i;
            F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
            default: data_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// Purpose : memory/write-back stage: ALU write-back, loads/stores over a req/ack port, bypass to execute.
// Latency : ALU op 1 cycle to writeflag; memory op 1 cycle to dmem_req, write-back the cycle after dmem_ack.
// Backpr. : ex_stall held while an access is outstanding, released combinationally in the ack cycle.
// Ports   : ex_ir/alu_out/b_reg from execute; dmem_* memory port; writeflag/dest_addr/MWB_Out register-file
//           write; bypass_flag/rs1_out/rs2_out forwarding to execute for ifd_rs1_addr/ifd_rs2_addr.
// Config  : MEM_WB_BYPASS_EN defined enables forwarding; undefined ties bypass outputs to zero.
module mem_wb_stage
    import mem_wb_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       ex_ir,
    input  logic [31:0]       alu_out,
    input  logic [31:0]       b_reg,
    input  logic [4:0]        ifd_rs1_addr,
    input  logic [4:0]        ifd_rs2_addr,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata,
    output logic              ex_stall,
    output logic              writeflag,
    output logic [4:0]        dest_addr,
    output logic [31:0]       MWB_Out,
    output logic [1:0]        bypass_flag,
    output logic [31:0]       rs1_out,
    output logic [31:0]       rs2_out
);

    mwb_state_e        state_q;
    logic              req_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [2:0]        funct3_q;
    logic [4:0]        rd_q;
    logic              writeflag_q;
    logic [4:0]        dest_q;
    logic [31:0]       mwb_q;

    ir_kind_e          kind;
    logic [31:0]       load_data;

    assign kind = classify_ir(ex_ir);

    mem_wb_load_align u_load_align (
        .rdata_i   (dmem_rdata),
        .addr_lo_i (addr_q[1:0]),
        .funct3_i  (funct3_q),
        .data_o    (load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 32'h0;
            funct3_q    <= 3'b000;
            rd_q        <= 5'd0;
            writeflag_q <= 1'b0;
            dest_q      <= 5'd0;
            mwb_q       <= 32'h0;
        end else begin
            // Write enable is a one-cycle pulse unless re-armed below
            writeflag_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    case (kind)
                        K_ALU: begin
                            mwb_q       <= alu_out;
                            dest_q      <= ex_ir[11:7];
                            writeflag_q <= |ex_ir[11:7];
                        end
                        K_LOAD, K_STORE: begin
                            addr_q   <= ADDR_W'(alu_out);
                            wdata_q  <= b_reg;
                            funct3_q <= ex_ir[14:12];
                            rd_q     <= ex_ir[11:7];
                            req_q    <= 1'b1;
                            we_q     <= (kind == K_STORE);
                            state_q  <= S_WAIT;
                        end
                        default: ;
                    endcase
                end
                S_WAIT: begin
                    // Execute is stalled, so ex_ir/alu_out/b_reg are not looked at here
                    if (dmem_ack) begin
                        state_q <= S_IDLE;
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        if (!we_q) begin
                            mwb_q       <= load_data;
                            dest_q      <= rd_q;
                            writeflag_q <= |rd_q;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign writeflag  = writeflag_q;
    assign dest_addr  = dest_q;
    assign MWB_Out    = mwb_q;

    // Dropping the stall in the ack cycle lets execute advance on the edge that leaves WAIT
    assign ex_stall = (state_q == S_WAIT) & ~dmem_ack;

`ifdef MEM_WB_BYPASS_EN
    assign bypass_flag[0] = writeflag_q & (dest_q != 5'd0) & (dest_q == ifd_rs1_addr);
    assign bypass_flag[1] = writeflag_q & (dest_q != 5'd0) & (dest_q == ifd_rs2_addr);
    assign rs1_out        = mwb_q;
    assign rs2_out        = mwb_q;
`else
    logic unused_rs_addr;
    assign unused_rs_addr = ^{ifd_rs1_addr, ifd_rs2_addr};
    assign bypass_flag    = 2'b00;
    assign rs1_out        = 32'h0;
    assign rs2_out        = 32'h0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Purpose : self-checking bench for mem_wb_stage: directed cases then random traffic vs a transaction model.
// Latency : n/a.
// Backpr. : bench plays the memory and acks after random delays.
module tb_mem_wb_stage;

`ifdef MEM_WB_BYPASS_EN
    localparam bit BP_EN = 1'b1;
`else
    localparam bit BP_EN = 1'b0;
`endif

    // Instruction classes the stimulus generator knows about
    localparam int KR   = 0;
    localparam int KI   = 1;
    localparam int KLD  = 2;
    localparam int KST  = 3;
    localparam int KBR  = 4;
    localparam int KOTH = 5;
    localparam int KBUB = 6;

    logic        clk;
    logic        rst_n;
    logic [31:0] ex_ir;
    logic [31:0] alu_out;
    logic [31:0] b_reg;
    logic [4:0]  ifd_rs1_addr;
    logic [4:0]  ifd_rs2_addr;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        ex_stall;
    logic        writeflag;
    logic [4:0]  dest_addr;
    logic [31:0] MWB_Out;
    logic [1:0]  bypass_flag;
    logic [31:0] rs1_out;
    logic [31:0] rs2_out;

    mem_wb_stage #(.ADDR_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex_ir        (ex_ir),
        .alu_out      (alu_out),
        .b_reg        (b_reg),
        .ifd_rs1_addr (ifd_rs1_addr),
        .ifd_rs2_addr (ifd_rs2_addr),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_ack     (dmem_ack),
        .dmem_rdata   (dmem_rdata),
        .ex_stall     (ex_stall),
        .writeflag    (writeflag),
        .dest_addr    (dest_addr),
        .MWB_Out      (MWB_Out),
        .bypass_flag  (bypass_flag),
        .rs1_out      (rs1_out),
        .rs2_out      (rs2_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    endtask

    // Reference model: one outstanding memory transaction plus the last register-file write
    bit          m_pend;
    bit          m_store;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [2:0]  m_f3;
    logic [4:0]  m_rd;
    bit          m_wf;
    logic [4:0]  m_dest;
    logic [31:0] m_mwb;

    function automatic void model_reset();
        m_pend = 0; m_store = 0; m_addr = 0; m_wdata = 0;
        m_f3 = 0; m_rd = 0; m_wf = 0; m_dest = 0; m_mwb = 0;
    endfunction

    // Load result by arithmetic: shift the wanted byte down, then fold it into a signed range
    function automatic logic [31:0] load_value(input logic [31:0] rdata, input logic [31:0] addr,
                                               input logic [2:0] f3);
        int off;
        int v;
        if (f3 == 3'b010) return rdata;
        if (f3 == 3'b000) begin
            off = int'(addr % 4);
            v = int'((rdata >> (8 * off)) % 256);
            if (v >= 128) v = v - 256;
            return 32'(v);
        end
        return 32'h0;
    endfunction

    function automatic void model_edge(input int kind, input logic [4:0] rd, input logic [2:0] f3,
                                       input logic [31:0] alu, input logic [31:0] b,
                                       input logic ack, input logic [31:0] rdata);
        m_wf = 0;
        if (m_pend) begin
            if (ack) begin
                m_pend = 0;
                if (!m_store) begin
                    m_mwb  = load_value(rdata, m_addr, m_f3);
                    m_dest = m_rd;
                    m_wf   = (m_rd != 0);
                end
            end
        end else if (kind == KR || kind == KI) begin
            m_mwb  = alu;
            m_dest = rd;
            m_wf   = (rd != 0);
        end else if (kind == KLD || kind == KST) begin
            m_pend  = 1;
            m_store = (kind == KST);
            m_addr  = alu;
            m_wdata = b;
            m_f3    = f3;
            m_rd    = rd;
        end
    endfunction

    function automatic logic [31:0] mk_ir(input int kind, input logic [4:0] rd, input logic [2:0] f3);
        logic [31:0] ir;
        logic [4:0]  op;
        logic [4:0]  others [5];
        others[0] = 5'b01101; others[1] = 5'b00101; others[2] = 5'b11011;
        others[3] = 5'b11001; others[4] = 5'b11100;
        if (kind == KBUB) return 32'hFFFF_FFFF;
        case (kind)
            KR:      op = 5'b01100;
            KI:      op = 5'b00100;
            KLD:     op = 5'b00000;
            KST:     op = 5'b01000;
            KBR:     op = 5'b11000;
            default: op = others[$urandom_range(0, 4)];
        endcase
        ir = $urandom;
        ir[14:12] = f3;
        ir[11:7]  = rd;
        ir[6:2]   = op;
        ir[1:0]   = 2'b11;
        return ir;
    endfunction

    task automatic check_outputs();
        logic [1:0]  eb;
        logic [31:0] er;
        chk("ex_stall", 32'(ex_stall), 32'(m_pend && !dmem_ack));
        chk("dmem_req", 32'(dmem_req), 32'(m_pend));
        if (m_pend) begin
            chk("dmem_we", 32'(dmem_we), 32'(m_store));
            chk("dmem_addr", dmem_addr, m_addr);
            if (m_store) chk("dmem_wdata", dmem_wdata, m_wdata);
        end
        chk("writeflag", 32'(writeflag), 32'(m_wf));
        chk("dest_addr", 32'(dest_addr), 32'(m_dest));
        chk("MWB_Out", MWB_Out, m_mwb);
        eb = 2'b00;
        er = 32'h0;
        if (BP_EN) begin
            eb[0] = m_wf && (m_dest != 0) && (m_dest == ifd_rs1_addr);
            eb[1] = m_wf && (m_dest != 0) && (m_dest == ifd_rs2_addr);
            er    = m_mwb;
        end
        chk("bypass_flag", 32'(bypass_flag), 32'(eb));
        chk("rs1_out", rs1_out, er);
        chk("rs2_out", rs2_out, er);
    endtask

    // One clock: drive at negedge, check after settling, advance the model at posedge
    task automatic step(input int kind, input logic [4:0] rd, input logic [2:0] f3,
                        input logic [31:0] alu, input logic [31:0] b,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic ack, input logic [31:0] rdata);
        @(negedge clk);
        ex_ir        = mk_ir(kind, rd, f3);
        alu_out      = alu;
        b_reg        = b;
        ifd_rs1_addr = rs1;
        ifd_rs2_addr = rs2;
        dmem_ack     = ack;
        dmem_rdata   = rdata;
        #1;
        check_outputs();
        @(posedge clk);
        model_edge(kind, rd, f3, alu, b, ack, rdata);
        #2;
    endtask

    initial begin
        rst_n = 1'b0;
        ex_ir = 32'hFFFF_FFFF; alu_out = 0; b_reg = 0;
        ifd_rs1_addr = 0; ifd_rs2_addr = 0; dmem_ack = 0; dmem_rdata = 0;
        model_reset();
        #1;
        chk("rst_req", 32'(dmem_req), 32'h0);
        chk("rst_stall", 32'(ex_stall), 32'h0);
        chk("rst_wf", 32'(writeflag), 32'h0);
        chk("rst_mwb", MWB_Out, 32'h0);
        chk("rst_bypass", 32'(bypass_flag), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // ADD rd=5 -> one-cycle write of 42
        step(KR, 5'd5, 3'b000, 32'h0000_002A, 32'h0, 5'd0, 5'd0, 1'b0, 32'h0);
        chk("add_wf", 32'(writeflag), 32'h1);
        chk("add_dest", 32'(dest_addr), 32'd5);
        chk("add_mwb", MWB_Out, 32'd42);
        step(KBUB, 5'd0, 3'b000, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0, 32'h0);
        chk("add_wf_low", 32'(writeflag), 32'h0);

        // LW rd=3 @0x40, ack on the third wait cycle
        step(KLD, 5'd3, 3'b010, 32'h40, 32'h0, 5'd0, 5'd0, 1'b0, 32'h0);
        chk("lw_stall", 32'(ex_stall), 32'h1);
        step(KBUB, 5'd0, 3'b000, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0, 32'h0);
        step(KBUB, 5'd0, 3'b000, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0, 32'h0);
        step(KBUB, 5'd0, 3'b000, 32'h0, 32'h0, 5'd0, 5'd0, 1'b1, 32'hDEAD_BEEF);
        chk("lw_mwb", MWB_Out, 32'hDEAD_BEEF);
        chk("lw_wf", 32'(writeflag), 32'h1);
        chk("lw_dest", 32'(dest_addr), 32'd3);

        // LB @0x41 picks byte 1 = 0x80
        step(KLD, 5'd4, 3'b000, 32'h41, 32'h0, 5'd0, 5'd0, 1'b0, 32'h0);
        step(KBUB, 5'd0, 3'b000, 32'h0, 32'h0, 5'd0, 5'd0, 1'b1, 32'h0000_8000);
        chk("lb_mwb", MWB_Out, 32'hFFFF_FF80);

        // SW @0x10 data 0x1234
        step(KST, 5'd9, 3'b010, 32'h10, 32'h1234, 5'd0, 5'd0, 1'b0, 32'h0);
        chk("sw_we", 32'(dmem_we), 32'h1);
        chk("sw_wdata", dmem_wdata, 32'h1234);
        step(KR, 5'd6, 3'b000, 32'h5555, 32'h9999, 5'd0, 5'd0, 1'b0, 32'h0);
        chk("sw_wdata_hold", dmem_wdata, 32'h1234);
        chk("sw_addr_hold", dmem_addr, 32'h10);
        step(KBUB, 5'd0, 3'b000, 32'h0, 32'h0, 5'd0, 5'd0, 1'b1, 32'h0);
        chk("sw_no_wf", 32'(writeflag), 32'h0);

        // Bypass after ADD rd=7, then rd=0 must not forward
        step(KR, 5'd7, 3'b000, 32'h77, 32'h0, 5'd0, 5'd0, 1'b0, 32'h0);
        ifd_rs1_addr = 5'd7; ifd_rs2_addr = 5'd7;
        #1;
        chk("byp_flag", 32'(bypass_flag), BP_EN ? 32'h3 : 32'h0);
        chk("byp_rs1", rs1_out, BP_EN ? 32'h77 : 32'h0);
        step(KI, 5'd0, 3'b000, 32'h88, 32'h0, 5'd0, 5'd0, 1'b0, 32'h0);
        ifd_rs1_addr = 5'd0; ifd_rs2_addr = 5'd0;
        #1;
        chk("byp_rd0", 32'(bypass_flag), 32'h0);
        step(KBUB, 5'd0, 3'b000, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0, 32'h0);
        chk("bubble_wf", 32'(writeflag), 32'h0);

        // Random traffic; ack also appears while idle and must be ignored there
        for (int i = 0; i < 1500; i++) begin
            int          k;
            logic [2:0]  f3;
            logic        ack;
            k   = int'($urandom_range(0, 6));
            f3  = ($urandom_range(0, 2) == 0) ? 3'($urandom) : (($urandom_range(0, 1) == 0) ? 3'b000 : 3'b010);
            ack = m_pend ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) == 0);
            step(k, 5'($urandom_range(0, 7)), f3, $urandom, $urandom,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), ack, $urandom);
        end

        // Reset in the middle of a wait: the access is dropped and a later ack does nothing
        step(KR, 5'd2, 3'b000, 32'h1111, 32'h0, 5'd0, 5'd0, m_pend, 32'h0);
        step(KLD, 5'd2, 3'b010, 32'h80, 32'h0, 5'd0, 5'd0, 1'b0, 32'h0);
        chk("rw_req_before", 32'(dmem_req), 32'h1);
        @(negedge clk);
        dmem_ack = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rw_req", 32'(dmem_req), 32'h0);
        chk("rw_stall", 32'(ex_stall), 32'h0);
        chk("rw_wf", 32'(writeflag), 32'h0);
        chk("rw_dest", 32'(dest_addr), 32'h0);
        chk("rw_mwb", MWB_Out, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(KBUB, 5'd0, 3'b000, 32'h0, 32'h0, 5'd0, 5'd0, 1'b1, 32'hCAFE_F00D);
        chk("rw_late_ack_wf", 32'(writeflag), 32'h0);
        step(KBUB, 5'd0, 3'b000, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory/write-back stage of the three-stage pipeline; the producer side of the execute stage's write-back and bypass interface. Consumes the execute stage's registered instruction, ALU result and store operand; performs loads and stores through a req/ack data-memory port; drives the register-file write (`writeflag`, `dest_addr`, `MWB_Out`) and the operand bypass flags back into execute. It stalls execute while a memory access is outstanding.

## Interface
Parameters
- `ADDR_W`, 32, data-memory address width

Ports
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `ex_ir`  in  32  instruction leaving execute; `32'hFFFF_FFFF` = bubble
- `alu_out`  in  32  ALU result / effective address
- `b_reg`  in  32  store data (rs2 value)
- `ifd_rs1_addr`, `ifd_rs2_addr`  in  5  source registers of the instruction entering execute
- `dmem_req`  out  1  memory request
- `dmem_we`  out  1  1 = store
- `dmem_addr`  out  ADDR_W  byte address
- `dmem_wdata`  out  32  store data
- `dmem_ack`  in  1  access complete; `dmem_rdata` valid this cycle for loads
- `dmem_rdata`  in  32  load data
- `ex_stall`  out  1  hold execute
- `writeflag`  out  1  register-file write enable
- `dest_addr`  out  5  destination register
- `MWB_Out`  out  32  write-back data
- `bypass_flag`  out  2  bit0 forward to rs1, bit1 forward to rs2
- `rs1_out`, `rs2_out`  out  32  forwarded operands

## Operation
- Decode on `ex_ir[6:2]`: 01100 R-type, 00100 I-type, 00000 load, 01000 store, 11000 branch; all else, and bubble, is a no-op.
- FSM states: IDLE, WAIT.
- IDLE, R/I-type: at next edge `MWB_Out<=alu_out`, `dest_addr<=ex_ir[11:7]`, `writeflag<=1` unless rd==0.
- IDLE, load/store: at next edge latch address `alu_out`, `b_reg`, funct3, rd; go WAIT; `dmem_req=1`, `dmem_we=1` for store.
- WAIT: address/wdata/we held stable; inputs `ex_ir`/`alu_out`/`b_reg` ignored; `writeflag=0`.
- WAIT with `dmem_ack`: go IDLE at edge. Load: funct3 010 (LW) writes `dmem_rdata`; funct3 000 (LB) writes byte `dmem_addr[1:0]` sign-extended; other funct3 write 0. `writeflag<=1` (rd≠0) for one cycle. Store: no write-back.
- Branch, bubble, no-op: `writeflag<=0`.
- `ex_stall = (state==WAIT) & ~dmem_ack` (combinational).
- `dmem_ack` in IDLE ignored.
- Bypass: `bypass_flag[0] = writeflag & (dest_addr!=0) & (dest_addr==ifd_rs1_addr)`; bit1 likewise for rs2; `rs1_out = rs2_out = MWB_Out`.

## Timing
- Reset (async, any state incl. WAIT): state IDLE; `dmem_req`, `dmem_we`, `writeflag`, `ex_stall`, `bypass_flag` = 0; `dest_addr`, `MWB_Out`, `dmem_addr`, `dmem_wdata` = 0. Pending access abandoned.
- ALU op presented cycle N → `writeflag` high cycle N+1, exactly one cycle.
- Load presented cycle N → `dmem_req` high from N+1; ack in cycle M (M≥N+1) → `writeflag`/data in M+1. Zero-wait memory: 2-cycle load.
- `ex_stall` low in the ack cycle so execute advances on the same edge WAIT exits.
- Back-to-back memory ops: second op seen in IDLE at M+1, `dmem_req` drops for at least one cycle between accesses.

## Configuration
- `MEM_WB_BYPASS_EN`: defined → bypass logic as above. Undefined → `bypass_flag=2'b00`, `rs1_out=rs2_out=0`; execute reads only the register file.

## Structure
- Package `mem_wb_pkg`: opcode constants (OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_BRANCH), `BUBBLE_IR`, funct3 constants (F3_LB, F3_LW, F3_SW), FSM state enum.
- One sub-module: `mem_wb_load_align` — combinational byte select and sign extension from rdata, addr[1:0], funct3.

## Test plan
- ADD rd=5, `alu_out=32'h0000_002A` → next cycle `writeflag=1`, `dest_addr=5`, `MWB_Out=42`; low the cycle after.
- LW rd=3 addr 0x40, ack after 3 cycles with rdata 0xDEAD_BEEF → `ex_stall` high 2 cycles, low on ack; next cycle `MWB_Out=0xDEAD_BEEF`, `writeflag=1`.
- LB addr 0x41, rdata 0x0000_8000 → `MWB_Out=0xFFFF_FF80`.
- SW addr 0x10 data 0x1234 → `dmem_we=1`, `dmem_wdata=0x1234` stable until ack; `writeflag` never high.
- ADD rd=7 followed by instruction with rs1=7, rs2=7 → `bypass_flag=2'b11`, `rs1_out=MWB_Out`; rd=0 → flags 0; bubble `0xFFFF_FFFF` → no write.
- `rst_n` low mid-WAIT → `dmem_req`, `ex_stall` drop immediately; later ack ignored, no write.
